mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter NUM_U, default 16, meaning the number of u-groups (POT terms) accumulated per output sample.
REQ-002 SHALL have port sclk, input, 1 bit: the single clock; all state updates on posedge sclk.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: a pulse that begins a new output sample.
REQ-005 SHALL have port term_valid, input, 1 bit: a term is offered.
REQ-006 SHALL have port term_ready, output, 1 bit: the block accepts the term this cycle.
REQ-007 SHALL have port term_data, input, 16 bits: the two's-complement data sample x(n-k).
REQ-008 SHALL have port term_sub, input, 1 bit: 1 means subtract the term, 0 means add it.
REQ-009 SHALL have port term_null, input, 1 bit: 1 means no add (empty group marker).
REQ-010 SHALL have port term_last, input, 1 bit: the term is the last one of its u-group.
REQ-011 SHALL have port acc_in, input, 40 bits: the shift-accumulator register value (out_bk).
REQ-012 SHALL have port add_out, output, 40 bits: drives the shift-accumulator in_bk.
REQ-013 SHALL have port load, output, 1 bit: drives the shift-accumulator load.
REQ-014 SHALL have port shift_en, output, 1 bit: drives the shift-accumulator shift_en.
REQ-015 SHALL have port clear, output, 1 bit: drives the shift-accumulator clear.
REQ-016 SHALL have port result, output, 40 bits: the captured final accumulator value.
REQ-017 SHALL have port result_valid, output, 1 bit: a one-cycle pulse, result valid.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, ACCUM, DONE.
REQ-019 SHALL move IDLE->CLEAR on start=1, CLEAR->ACCUM after one cycle, ACCUM->DONE when term_last of group NUM_U is accepted, and DONE->IDLE after one cycle.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 SHALL assert clear only in the CLEAR state, with load=0.
REQ-022 SHALL assert term_ready only in ACCUM; a term is accepted when term_valid and term_ready are both 1.
REQ-023 SHALL leave terms offered outside ACCUM unconsumed.
REQ-024 SHALL sign-extend term to ext = {8x term_data[15], term_data, 16'h0000}.
REQ-025 SHALL, on acceptance, register add_out = acc_in + ext (term_sub=0), acc_in - ext (term_sub=1), or acc_in (term_null=1), with 40-bit two's-complement wrap-around and no saturation.
REQ-026 SHALL, on acceptance, register load=1 and shift_en=term_last for exactly the following cycle; otherwise load=0 and shift_en=0.
REQ-027 SHALL present load, shift_en, clear and add_out from posedge so that they are stable at the accumulator's negedge sampling point.
REQ-028 SHALL sustain throughput of one term per sclk, because acc_in has settled by the next posedge.
REQ-029 SHALL count groups with a u-counter of width clog2(NUM_U+1) that increments on each accepted term_last and resets to 0 in CLEAR.
REQ-030 SHALL capture result <= acc_in at the DONE->IDLE edge and assert result_valid for that one following cycle, giving a latency of 2 posedges from the final acceptance.
REQ-031 SHALL hold result until the next capture.
REQ-032 SHALL treat term_null=1 with term_last=0 as a no-op add that still asserts load.

Reset
REQ-033 SHALL, on reset_n=0 at any time including mid-sample, force state IDLE, u-counter 0, term_ready 0, load 0, shift_en 0, clear 0, add_out 0, result 0 and result_valid 0.
REQ-034 SHALL require a new start after reset deasserts; no partial sample resumes.

Structure
REQ-035 SHALL place the state enum and the constants ACC_W=40, DATA_W=16, FRAC_W=16 and GUARD_W=8 in shared package msdap_pkg.
REQ-036 SHALL use one combinational sub-module, addsub_40 (ext generation plus add/subtract/pass); everything else is inline.

Verification
REQ-037 SHALL verify: NUM_U=2; terms +0x0001 last, then +0x0002 last -> add_out 0x0000010000 then 0x0000028000, shift_en=1 both times; result 0x0000014000.
REQ-038 SHALL verify: NUM_U=1; term 0x8000, term_sub=1, last -> add_out 0x0080000000; result 0x0040000000 (sign extension and negation).
REQ-039 SHALL verify: NUM_U=1; term -0x0001 added (0xFFFF, sub=0), last -> result 0xFFFFFF8000 (arithmetic shift).
REQ-040 SHALL verify: NUM_U=2; term_null last, then +0x0004 last -> result 0x0000020000, with load asserted for both terms.
REQ-041 SHALL verify: reset_n pulsed low mid-ACCUM -> all outputs 0 within the reset assertion; a following start runs a clean sample matching REQ-037.
REQ-042 SHALL verify: start re-pulsed during ACCUM and term_valid held in IDLE -> both ignored (no clear, term_ready=0); result is unchanged.

Source files
------------

// File: rtl/msdap_pkg.sv
// Shared constants and state encoding for the MSDAP multiply-accumulate path.
package msdap_pkg;

   localparam int ACC_W   = 40;
   localparam int DATA_W  = 16;
   localparam int FRAC_W  = 16;
   localparam int GUARD_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      ACCUM = 2'd2,
      DONE  = 2'd3
   } ms_state_t;

endpackage

// File: rtl/addsub_40.sv
// Places a 16-bit sample in the middle of the 40-bit accumulator word
// (guard bits above, fraction bits below) and adds, subtracts or passes it.
module addsub_40
   import msdap_pkg::*;
(
   input  logic [ACC_W-1:0]  acc_in,
   input  logic [DATA_W-1:0] term_data,
   input  logic              term_sub,
   input  logic              term_null,
   output logic [ACC_W-1:0]  sum
);

   logic [ACC_W-1:0] ext;

   assign ext = {{GUARD_W{term_data[DATA_W-1]}}, term_data, {FRAC_W{1'b0}}};

   // An empty group marker leaves the accumulator value untouched.
   always_comb begin
      sum = acc_in;
      if (!term_null) begin
         if (term_sub) begin
            sum = acc_in - ext;
         end else begin
            sum = acc_in + ext;
         end
      end
   end

endmodule

// File: rtl/mac_sequencer.sv
// Sequences POT terms into an external shift-accumulator: clears it, feeds
// one add/sub per accepted term, shifts at the end of each u-group and
// captures the final value after NUM_U groups.
module mac_sequencer
   import msdap_pkg::*;
#(
   parameter int NUM_U = 16
)
(
   input  logic              sclk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              term_valid,
   output logic              term_ready,
   input  logic [DATA_W-1:0] term_data,
   input  logic              term_sub,
   input  logic              term_null,
   input  logic              term_last,
   input  logic [ACC_W-1:0]  acc_in,
   output logic [ACC_W-1:0]  add_out,
   output logic              load,
   output logic              shift_en,
   output logic              clear,
   output logic [ACC_W-1:0]  result,
   output logic              result_valid
);

   localparam int U_W = $clog2(NUM_U + 1);
   localparam logic [U_W-1:0] LAST_U = U_W'(NUM_U - 1);

   ms_state_t        state;
   ms_state_t        state_next;
   logic [U_W-1:0]   u_count;
   logic [ACC_W-1:0] sum;
   logic             accept;
   logic             final_term;

   addsub_40 u_addsub (
      .acc_in    (acc_in),
      .term_data (term_data),
      .term_sub  (term_sub),
      .term_null (term_null),
      .sum       (sum)
   );

   assign term_ready = (state == ACCUM);
   assign clear      = (state == CLEAR);
   assign accept     = term_valid && term_ready;
   assign final_term = accept && term_last && (u_count == LAST_U);

   // State register; reset always abandons any partial sample.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; start is only honoured from IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CLEAR;
         CLEAR:   state_next = ACCUM;
         ACCUM:   if (final_term) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Group counter, cleared together with the accumulator.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         u_count <= '0;
      end else if (state == CLEAR) begin
         u_count <= '0;
      end else if (accept && term_last) begin
         u_count <= u_count + 1'b1;
      end
   end

   // Accumulator controls are registered so they are settled well before the
   // accumulator samples them on the falling edge.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         add_out  <= '0;
         load     <= 1'b0;
         shift_en <= 1'b0;
      end else begin
         load     <= accept;
         shift_en <= accept && term_last;
         if (accept) begin
            add_out <= sum;
         end
      end
   end

   // Capture the finished sample on leaving DONE and flag it for one cycle.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= (state == DONE);
         if (state == DONE) begin
            result <= acc_in;
         end
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural shift-accumulator model.
// dut2 runs with NUM_U=2, dut1 with NUM_U=1; sel picks which one is observed.
module tb_mac_sequencer;

   logic        sclk = 1'b0;
   logic        reset_n;
   logic        start2, start1;
   logic        term_valid, term_sub, term_null, term_last;
   logic [15:0] term_data;

   logic [39:0] acc2, acc1, add_out2, add_out1, result2, result1;
   logic        ready2, ready1, load2, load1, shift2, shift1;
   logic        clear2, clear1, rv2, rv1;

   logic        sel;
   logic [39:0] obs_add_out, obs_result;
   logic        obs_ready, obs_load, obs_shift, obs_clear, obs_rv;

   int checks = 0;
   int errors = 0;

   always #5 sclk = ~sclk;

   mac_sequencer #(.NUM_U(2)) dut2 (
      .sclk(sclk), .reset_n(reset_n), .start(start2),
      .term_valid(term_valid), .term_ready(ready2), .term_data(term_data),
      .term_sub(term_sub), .term_null(term_null), .term_last(term_last),
      .acc_in(acc2), .add_out(add_out2), .load(load2), .shift_en(shift2),
      .clear(clear2), .result(result2), .result_valid(rv2)
   );

   mac_sequencer #(.NUM_U(1)) dut1 (
      .sclk(sclk), .reset_n(reset_n), .start(start1),
      .term_valid(term_valid), .term_ready(ready1), .term_data(term_data),
      .term_sub(term_sub), .term_null(term_null), .term_last(term_last),
      .acc_in(acc1), .add_out(add_out1), .load(load1), .shift_en(shift1),
      .clear(clear1), .result(result1), .result_valid(rv1)
   );

   assign obs_add_out = sel ? add_out1 : add_out2;
   assign obs_result  = sel ? result1  : result2;
   assign obs_ready   = sel ? ready1   : ready2;
   assign obs_load    = sel ? load1    : load2;
   assign obs_shift   = sel ? shift1   : shift2;
   assign obs_clear   = sel ? clear1   : clear2;
   assign obs_rv      = sel ? rv1      : rv2;

   // Shift-accumulator model: negedge sampling, arithmetic right shift on group end.
   always @(negedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         acc2 <= '0;
         acc1 <= '0;
      end else begin
         if (clear2) acc2 <= '0;
         else if (load2) acc2 <= shift2 ? 40'($signed(add_out2) >>> 1) : add_out2;
         if (clear1) acc1 <= '0;
         else if (load1) acc1 <= shift1 ? 40'($signed(add_out1) >>> 1) : add_out1;
      end
   end

   task automatic do_start();
      if (sel) start1 = 1'b1; else start2 = 1'b1;
      @(posedge sclk); #1;
      start1 = 1'b0;
      start2 = 1'b0;
   endtask

   // Offers one term and holds it until accepted or the cycle budget expires.
   task automatic send_term(input logic [15:0] d, input logic s, input logic nl,
                            input logic lst, output bit timeout);
      int n = 0;
      term_data  = d;
      term_sub   = s;
      term_null  = nl;
      term_last  = lst;
      term_valid = 1'b1;
      while (!obs_ready && n < 20) begin
         @(posedge sclk); #1;
         n++;
      end
      timeout = !obs_ready;
      if (!timeout) begin
         @(posedge sclk); #1;
      end
      term_valid = 1'b0;
      term_null  = 1'b0;
      term_sub   = 1'b0;
   endtask

   task automatic test_reset();
      sel = 1'b0;
      checks++; if (obs_ready !== 1'b0 || obs_load !== 1'b0 || obs_shift !== 1'b0 || obs_clear !== 1'b0 || obs_rv !== 1'b0) begin errors++; $display("[TB] FAIL reset_ctrl2: got rdy=%b ld=%b sh=%b clr=%b rv=%b expected all 0", obs_ready, obs_load, obs_shift, obs_clear, obs_rv); end
      checks++; if (obs_add_out !== 40'h0 || obs_result !== 40'h0) begin errors++; $display("[TB] FAIL reset_data2: got add_out=%h result=%h expected 0", obs_add_out, obs_result); end
      sel = 1'b1;
      checks++; if (obs_ready !== 1'b0 || obs_load !== 1'b0 || obs_clear !== 1'b0 || obs_result !== 40'h0) begin errors++; $display("[TB] FAIL reset_dut1: got rdy=%b ld=%b clr=%b result=%h expected 0", obs_ready, obs_load, obs_clear, obs_result); end
   endtask

   // Two groups, +1 then +2, with shifts between them.
   task automatic test_basic(input string tag);
      bit to;
      sel = 1'b0;
      do_start();
      checks++; if (obs_clear !== 1'b1 || obs_load !== 1'b0) begin errors++; $display("[TB] FAIL %s_clear: got clear=%b load=%b expected 1/0", tag, obs_clear, obs_load); end
      send_term(16'h0001, 1'b0, 1'b0, 1'b1, to);
      checks++; if (to) begin errors++; $display("[TB] FAIL %s_t1_timeout: got timeout=1 expected 0", tag); end
      checks++; if (obs_add_out !== 40'h0000010000) begin errors++; $display("[TB] FAIL %s_t1_add: got %h expected 0000010000", tag, obs_add_out); end
      checks++; if (obs_load !== 1'b1 || obs_shift !== 1'b1) begin errors++; $display("[TB] FAIL %s_t1_ctrl: got load=%b shift=%b expected 1/1", tag, obs_load, obs_shift); end
      send_term(16'h0002, 1'b0, 1'b0, 1'b1, to);
      checks++; if (to) begin errors++; $display("[TB] FAIL %s_t2_timeout: got timeout=1 expected 0", tag); end
      checks++; if (obs_add_out !== 40'h0000028000) begin errors++; $display("[TB] FAIL %s_t2_add: got %h expected 0000028000", tag, obs_add_out); end
      checks++; if (obs_shift !== 1'b1 || obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL %s_t2_ctrl: got shift=%b ready=%b expected 1/0", tag, obs_shift, obs_ready); end
      @(posedge sclk); #1;
      checks++; if (obs_rv !== 1'b1 || obs_result !== 40'h0000014000) begin errors++; $display("[TB] FAIL %s_result: got rv=%b result=%h expected 1/0000014000", tag, obs_rv, obs_result); end
      @(posedge sclk); #1;
      checks++; if (obs_rv !== 1'b0 || obs_load !== 1'b0 || obs_result !== 40'h0000014000) begin errors++; $display("[TB] FAIL %s_after: got rv=%b load=%b result=%h expected 0/0/0000014000", tag, obs_rv, obs_load, obs_result); end
   endtask

   // 0x8000 subtracted: most negative sample negated.
   task automatic test_negate();
      bit to;
      sel = 1'b1;
      do_start();
      send_term(16'h8000, 1'b1, 1'b0, 1'b1, to);
      checks++; if (to || obs_add_out !== 40'h0080000000) begin errors++; $display("[TB] FAIL negate_add: got to=%b add_out=%h expected 0/0080000000", to, obs_add_out); end
      @(posedge sclk); #1;
      checks++; if (obs_rv !== 1'b1 || obs_result !== 40'h0040000000) begin errors++; $display("[TB] FAIL negate_result: got rv=%b result=%h expected 1/0040000000", obs_rv, obs_result); end
   endtask

   // -1 added, then an arithmetic shift must keep the sign.
   task automatic test_minus_one();
      bit to;
      sel = 1'b1;
      do_start();
      send_term(16'hFFFF, 1'b0, 1'b0, 1'b1, to);
      checks++; if (to || obs_add_out !== 40'hFFFFFF0000) begin errors++; $display("[TB] FAIL minus1_add: got to=%b add_out=%h expected 0/ffffff0000", to, obs_add_out); end
      @(posedge sclk); #1;
      checks++; if (obs_result !== 40'hFFFFFF8000) begin errors++; $display("[TB] FAIL minus1_result: got %h expected ffffff8000", obs_result); end
   endtask

   // Empty first group still loads; second group +4.
   task automatic test_null();
      bit to;
      sel = 1'b0;
      do_start();
      send_term(16'h1234, 1'b0, 1'b1, 1'b1, to);
      checks++; if (to || obs_load !== 1'b1 || obs_add_out !== 40'h0) begin errors++; $display("[TB] FAIL null_t1: got to=%b load=%b add_out=%h expected 0/1/0", to, obs_load, obs_add_out); end
      send_term(16'h0004, 1'b0, 1'b0, 1'b1, to);
      checks++; if (to || obs_load !== 1'b1 || obs_add_out !== 40'h0000040000) begin errors++; $display("[TB] FAIL null_t2: got to=%b load=%b add_out=%h expected 0/1/0000040000", to, obs_load, obs_add_out); end
      @(posedge sclk); #1;
      checks++; if (obs_result !== 40'h0000020000) begin errors++; $display("[TB] FAIL null_result: got %h expected 0000020000", obs_result); end
   endtask

   // Reset in the middle of a sample, then a clean rerun.
   task automatic test_reset_mid();
      bit to;
      sel = 1'b0;
      do_start();
      send_term(16'h0001, 1'b0, 1'b0, 1'b1, to);
      checks++; if (to || obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_accum: got to=%b ready=%b expected 0/1", to, obs_ready); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (obs_ready !== 1'b0 || obs_load !== 1'b0 || obs_shift !== 1'b0 || obs_clear !== 1'b0 || obs_rv !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ctrl: got rdy=%b ld=%b sh=%b clr=%b rv=%b expected all 0", obs_ready, obs_load, obs_shift, obs_clear, obs_rv); end
      checks++; if (obs_add_out !== 40'h0 || obs_result !== 40'h0) begin errors++; $display("[TB] FAIL rmid_data: got add_out=%h result=%h expected 0", obs_add_out, obs_result); end
      @(posedge sclk); #1;
      reset_n = 1'b1;
      repeat (2) begin
         @(posedge sclk); #1;
         checks++; if (obs_ready !== 1'b0 || obs_clear !== 1'b0) begin errors++; $display("[TB] FAIL rmid_noresume: got ready=%b clear=%b expected 0/0", obs_ready, obs_clear); end
      end
      test_basic("rerun");
   endtask

   // Restart during ACCUM and a term waiting in IDLE are both ignored.
   task automatic test_ignore();
      bit to;
      sel = 1'b0;
      do_start();
      send_term(16'h0001, 1'b0, 1'b0, 1'b1, to);
      checks++; if (to) begin errors++; $display("[TB] FAIL ign_t1_timeout: got timeout=1 expected 0"); end
      start2 = 1'b1;
      @(posedge sclk); #1;
      start2 = 1'b0;
      checks++; if (obs_clear !== 1'b0 || obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL ign_restart: got clear=%b ready=%b expected 0/1", obs_clear, obs_ready); end
      send_term(16'h0002, 1'b0, 1'b0, 1'b1, to);
      @(posedge sclk); #1;
      checks++; if (to || obs_rv !== 1'b1 || obs_result !== 40'h0000014000) begin errors++; $display("[TB] FAIL ign_result: got to=%b rv=%b result=%h expected 0/1/0000014000", to, obs_rv, obs_result); end
      @(posedge sclk); #1;
      term_data  = 16'h0007;
      term_last  = 1'b1;
      term_valid = 1'b1;
      repeat (3) begin
         @(posedge sclk); #1;
         checks++; if (obs_ready !== 1'b0 || obs_load !== 1'b0 || obs_clear !== 1'b0 || obs_rv !== 1'b0) begin errors++; $display("[TB] FAIL ign_idle: got ready=%b load=%b clear=%b rv=%b expected all 0", obs_ready, obs_load, obs_clear, obs_rv); end
         checks++; if (obs_result !== 40'h0000014000) begin errors++; $display("[TB] FAIL ign_hold: got %h expected 0000014000", obs_result); end
      end
      term_valid = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      start2     = 1'b0;
      start1     = 1'b0;
      term_valid = 1'b0;
      term_sub   = 1'b0;
      term_null  = 1'b0;
      term_last  = 1'b0;
      term_data  = 16'h0;
      sel        = 1'b0;
      repeat (2) @(posedge sclk);
      #1;
      test_reset();
      reset_n = 1'b1;
      @(posedge sclk); #1;
      test_basic("basic");
      test_negate();
      test_minus_one();
      test_null();
      test_reset_mid();
      test_ignore();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
